register_bank_p: RTL and testbench
==================================

# register_bank_p

Parametrised multi-port register bank for the processor datapath: one write port, `NRD` asynchronous read ports, a hardwired zero entry and a registered output-register tap. After reset, a clear sequencer zeroes every entry, so reset no longer depends on a first-clock initialisation. An optional write-to-read bypass removes the same-cycle read-after-write hazard for the decode stage.

## Interface

Parameters:

- `DATA_W`, 32: entry width in bits.
- `ADDR_W`, 5: address width; `DEPTH = 2**ADDR_W` entries.
- `NRD`, 4: number of read ports.
- `OUT_IDX`, 6: index of the entry mirrored on `regOUT`. Legal range is 1..DEPTH-1.
- `BYPASS`, 1: 1 forwards same-cycle write data to matching reads; 0 disables forwarding.

Ports:

- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `wrEn`, input, 1: write request.
- `addrW`, input, `ADDR_W`: write address.
- `data`, input, `DATA_W`: write data.
- `addrR`, input, `NRD*ADDR_W`: read addresses. Port k is `addrR[k*ADDR_W +: ADDR_W]`.
- `readR`, output, `NRD*DATA_W`: read data. Port k is `readR[k*DATA_W +: DATA_W]`.
- `regOUT`, output, `DATA_W`: registered copy of entry `OUT_IDX`.
- `busy`, output, 1: clear sequence in progress.
- `wrDrop`, output, 1: one-cycle pulse when a write was discarded.

## Operation

- FSM states are CLEAR and RUN. A clear counter `clrIdx` is `ADDR_W` bits wide.
- While `reset` is low: state=CLEAR, `clrIdx`=0, `busy`=1, `regOUT`=0, `wrDrop`=0. Storage is not reset directly.
- In CLEAR, each rising edge writes 0 to `registers[clrIdx]` and increments `clrIdx`.
  - The edge that clears entry DEPTH-1 moves the FSM to RUN.
  - `clrIdx` wraps to 0.
- In RUN, on a rising edge with `wrEn`=1 and `addrW`!=0: `registers[addrW]` <= `data`.
  - `wrEn`=1 with `addrW`=0 is ignored silently. It is not a drop.
- `wrEn`=1 while in CLEAR: the write is discarded, and `wrDrop`=1 on the following cycle.
- Reads are combinational, evaluated independently per port:
  - `busy`=1: returns 0.
  - Address 0: returns 0 always.
  - `BYPASS`=1, RUN, `wrEn`=1, `addrW`==address!=0: returns `data`.
  - Otherwise: returns `registers[address]`.
- All `NRD` ports may address the same entry simultaneously. There is no port priority.
- `regOUT` behaviour:
  - Cleared during CLEAR.
  - In RUN, loads `data` on every accepted write to `OUT_IDX`.
  - Always equals the stored value of `OUT_IDX`; it is not bypassed.
- Asserting reset mid-clear or mid-operation aborts everything. The clear sequence restarts from entry 0 after reset deassertion.

## Timing

- Reset values: `busy`=1, `regOUT`=0, `wrDrop`=0, all `readR`=0.
- Clear latency: after `reset` rises, `busy` stays 1 for exactly DEPTH rising edges (32 at defaults). It falls after the edge that clears entry DEPTH-1.
- First accepted write: the edge after `busy` falls.
- Write latency: stored at the rising edge.
  - With `BYPASS`=0, a same-cycle read returns the old value; the new value is visible from the next cycle.
  - With `BYPASS`=1, the new value is visible in the same cycle.
- `regOUT` updates at the write edge and is valid the cycle after.
- `wrDrop` is a registered pulse, exactly one cycle per dropped write. Back-to-back dropped writes hold it high.
- The path from `data`/`addrW` to `readR` is combinational when `BYPASS`=1. Consumers must budget for it.

## Test plan

- Reset clear: preload garbage by writing 0xDEADBEEF to all entries, pulse `reset` low, release. `busy`=1 for 32 cycles, then 0. Every entry then reads 0 on all four ports.
- Write/read: write 0x12345678 to entry 5. With `BYPASS`=0, the same-cycle read of 5 returns 0 and the next cycle returns 0x12345678 on all ports.
- Bypass: with `BYPASS`=1, write 0xA5A5A5A5 to entry 9 while ports 0 and 3 read 9. Both ports show 0xA5A5A5A5 in that same cycle. Ports 1 and 2 reading 8 show the stored value of 8.
- Zero entry: write 0xFFFFFFFF to address 0. All reads of 0 return 0, and `wrDrop` stays 0.
- Drop during clear: assert `wrEn` to entry 3 with data 0x77 on clear cycle 10. `wrDrop`=1 on cycle 11, and entry 3 reads 0 after `busy` falls.
- `regOUT` and mid-op reset: write 0x55 to entry 6 and check `regOUT`=0x55 one cycle later. Assert `reset` low mid-cycle: `regOUT`=0 and `busy`=1 immediately. After release there is a full 32-cycle clear, and entry 6 reads 0.

Source files
------------

// File: rtl/register_bank_p.sv
// rtl/register_bank_p.sv - multi-port register bank with clear sequencer and write bypass
module register_bank_p #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NRD     = 4,
   parameter int OUT_IDX = 6,
   parameter int BYPASS  = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wrEn,
   input  logic [ADDR_W-1:0]        addrW,
   input  logic [DATA_W-1:0]        data,
   input  logic [NRD*ADDR_W-1:0]    addrR,
   output logic [NRD*DATA_W-1:0]    readR,
   output logic [DATA_W-1:0]        regOUT,
   output logic                     busy,
   output logic                     wrDrop
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;
   localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(OUT_IDX);

   logic [0:0]        r_state;
   logic [ADDR_W-1:0] r_clr_idx;
   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DATA_W-1:0] r_reg_out;
   logic              r_wr_drop;

   logic              w_busy;
   logic              w_wr_accept;
   logic              w_clear_last;
   logic [ADDR_W-1:0] w_rd_addr;

   // Reset drives the FSM straight to CLEAR, so busy asserts without waiting for a clock.
   assign w_busy       = (r_state == ST_CLEAR);
   assign w_wr_accept  = !w_busy && wrEn && (addrW != '0);
   assign w_clear_last = &r_clr_idx;

   // Clear sequencer: walk every entry once, then hand over to normal operation.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state   <= ST_CLEAR;
         r_clr_idx <= '0;
      end else if (w_busy) begin
         r_clr_idx <= r_clr_idx + ADDR_W'(1);
         if (w_clear_last) begin
            r_state <= ST_RUN;
         end
      end
   end

   // Storage has no reset; the sequencer zeroes it, and busy masks reads until then.
   always_ff @(posedge clock) begin
      if (w_busy) begin
         r_regs[r_clr_idx] <= '0;
      end else if (w_wr_accept) begin
         r_regs[addrW] <= data;
      end
   end

   // Output tap mirrors the stored OUT_IDX value; drop flag reports writes refused during clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_reg_out <= '0;
         r_wr_drop <= 1'b0;
      end else begin
         r_wr_drop <= w_busy && wrEn;
         if (w_busy) begin
            r_reg_out <= '0;
         end else if (w_wr_accept && (addrW == OUT_ADDR)) begin
            r_reg_out <= data;
         end
      end
   end

   // Independent combinational read ports with optional same-cycle forwarding of write data.
   always_comb begin
      readR     = '0;
      w_rd_addr = '0;
      for (int k = 0; k < NRD; k++) begin
         w_rd_addr = addrR[k*ADDR_W +: ADDR_W];
         if (w_busy || (w_rd_addr == '0)) begin
            readR[k*DATA_W +: DATA_W] = '0;
         end else if ((BYPASS != 0) && wrEn && (addrW == w_rd_addr)) begin
            readR[k*DATA_W +: DATA_W] = data;
         end else begin
            readR[k*DATA_W +: DATA_W] = r_regs[w_rd_addr];
         end
      end
   end

   assign regOUT = r_reg_out;
   assign busy   = w_busy;
   assign wrDrop = r_wr_drop;

endmodule

// File: tb/tb_register_bank_p.sv
// tb/tb_register_bank_p.sv - self-checking bench for register_bank_p, bypass on and off
module tb_register_bank_p;
   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int NRD     = 4;
   localparam int DEPTH   = 32;
   localparam int OUT_IDX = 6;

   logic                  clock = 1'b0;
   logic                  reset = 1'b0;
   logic                  wrEn  = 1'b0;
   logic [ADDR_W-1:0]     addrW = '0;
   logic [DATA_W-1:0]     data  = '0;
   logic [NRD*ADDR_W-1:0] addrR = '0;
   logic [NRD*DATA_W-1:0] rd0, rd1;
   logic [DATA_W-1:0]     ro0, ro1;
   logic                  bz0, bz1, dr0, dr1;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: stored contents, remaining clear edges, output tap, drop flag
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_clear_left = DEPTH;
   logic [DATA_W-1:0] m_out  = '0;
   logic              m_drop = 1'b0;

   register_bank_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .OUT_IDX(OUT_IDX), .BYPASS(0)) dut_b0 (
      .clock(clock), .reset(reset), .wrEn(wrEn), .addrW(addrW), .data(data), .addrR(addrR),
      .readR(rd0), .regOUT(ro0), .busy(bz0), .wrDrop(dr0));

   register_bank_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .OUT_IDX(OUT_IDX), .BYPASS(1)) dut_b1 (
      .clock(clock), .reset(reset), .wrEn(wrEn), .addrW(addrW), .data(data), .addrR(addrR),
      .readR(rd1), .regOUT(ro1), .busy(bz1), .wrDrop(dr1));

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [DATA_W-1:0] exp_read(input bit byp, input logic [ADDR_W-1:0] a);
      if (m_clear_left > 0 || a == '0) return '0;
      if (byp && wrEn && addrW == a) return data;
      return m_mem[a];
   endfunction

   // apply one rising edge to the model with the current inputs, then advance past it
   task automatic cycle();
      if (reset) begin
         if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = '0;
            m_drop = wrEn;
            m_out  = '0;
            m_clear_left--;
         end else begin
            m_drop = 1'b0;
            if (wrEn && addrW != '0) begin
               m_mem[addrW] = data;
               if (addrW == OUT_IDX) m_out = data;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic assert_reset();
      reset        = 1'b0;
      m_clear_left = DEPTH;
      m_out        = '0;
      m_drop       = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (bz0 !== 1'b1 || bz1 !== 1'b1) begin
         n_fail++; $display("FAIL reset_busy: got %b/%b expected 1", bz0, bz1);
      end
      n_checks++;
      if (ro0 !== '0 || ro1 !== '0 || dr0 !== 1'b0 || dr1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_outs: regOUT %h/%h wrDrop %b/%b expected 0", ro0, ro1, dr0, dr1);
      end
      n_checks++;
      if (rd0 !== '0 || rd1 !== '0) begin
         n_fail++; $display("FAIL reset_reads: got %h/%h expected 0", rd0, rd1);
      end
      cycle();
      cycle();
      reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (bz0 !== 1'b1 || bz1 !== 1'b1) begin
            n_fail++; $display("FAIL reset_clear_busy[%0d]: got %b/%b expected 1", i, bz0, bz1);
         end
         cycle();
      end
      n_checks++;
      if (bz0 !== 1'b0 || bz1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_clear_done: busy %b/%b expected 0", bz0, bz1);
      end
   endtask

   task automatic test_preload_clear();
      wrEn = 1'b1;
      data = 32'hDEADBEEF;
      for (int a = 0; a < DEPTH; a++) begin
         addrW = ADDR_W'(a);
         cycle();
      end
      wrEn  = 1'b0;
      addrR = {4{5'd17}};
      #1;
      n_checks++;
      if (rd0[31:0] !== 32'hDEADBEEF || rd1[31:0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL preload_17: got %h/%h expected deadbeef", rd0[31:0], rd1[31:0]);
      end
      assert_reset();
      #1;
      n_checks++;
      if (bz0 !== 1'b1 || bz1 !== 1'b1 || rd0 !== '0 || rd1 !== '0) begin
         n_fail++; $display("FAIL preload_reset_async: busy %b/%b reads %h/%h", bz0, bz1, rd0[31:0], rd1[31:0]);
      end
      cycle();
      reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (bz0 !== 1'b1 || bz1 !== 1'b1) begin
            n_fail++; $display("FAIL preload_busy[%0d]: got %b/%b expected 1", i, bz0, bz1);
         end
         cycle();
      end
      n_checks++;
      if (bz0 !== 1'b0 || bz1 !== 1'b0) begin
         n_fail++; $display("FAIL preload_busy_fall: got %b/%b expected 0", bz0, bz1);
      end
      for (int a = 0; a < DEPTH; a++) begin
         addrR = {4{ADDR_W'(a)}};
         #1;
         n_checks++;
         if (rd0 !== '0 || rd1 !== '0) begin
            n_fail++; $display("FAIL preload_cleared[%0d]: got %h/%h expected 0", a, rd0, rd1);
         end
         cycle();
      end
   endtask

   task automatic test_write_read();
      wrEn  = 1'b1;
      addrW = 5'd5;
      data  = 32'h12345678;
      addrR = {4{5'd5}};
      #1;
      n_checks++;
      if (rd0 !== '0) begin
         n_fail++; $display("FAIL wr_same_cycle_nobypass: got %h expected 0", rd0);
      end
      n_checks++;
      if (rd1 !== {4{32'h12345678}}) begin
         n_fail++; $display("FAIL wr_same_cycle_bypass: got %h expected 4x12345678", rd1);
      end
      cycle();
      wrEn = 1'b0;
      data = '0;
      #1;
      n_checks++;
      if (rd0 !== {4{32'h12345678}} || rd1 !== {4{32'h12345678}}) begin
         n_fail++; $display("FAIL wr_next_cycle: got %h/%h expected 4x12345678", rd0, rd1);
      end
   endtask

   task automatic test_bypass();
      logic [DATA_W-1:0] v8;
      v8    = $urandom;
      wrEn  = 1'b1;
      addrW = 5'd8;
      data  = v8;
      cycle();
      addrW = 5'd9;
      data  = 32'hA5A5A5A5;
      addrR = {5'd9, 5'd8, 5'd8, 5'd9};
      #1;
      n_checks++;
      if (rd1 !== {32'hA5A5A5A5, v8, v8, 32'hA5A5A5A5}) begin
         n_fail++; $display("FAIL bypass_on: got %h expected %h", rd1, {32'hA5A5A5A5, v8, v8, 32'hA5A5A5A5});
      end
      n_checks++;
      if (rd0 !== {32'h0, v8, v8, 32'h0}) begin
         n_fail++; $display("FAIL bypass_off: got %h expected %h", rd0, {32'h0, v8, v8, 32'h0});
      end
      cycle();
      wrEn = 1'b0;
      #1;
      n_checks++;
      if (rd0[31:0] !== 32'hA5A5A5A5 || rd1[127:96] !== 32'hA5A5A5A5) begin
         n_fail++; $display("FAIL bypass_stored: got %h/%h expected a5a5a5a5", rd0[31:0], rd1[127:96]);
      end
   endtask

   task automatic test_zero();
      wrEn  = 1'b1;
      addrW = '0;
      data  = 32'hFFFFFFFF;
      addrR = '0;
      #1;
      n_checks++;
      if (rd0 !== '0 || rd1 !== '0) begin
         n_fail++; $display("FAIL zero_same_cycle: got %h/%h expected 0", rd0, rd1);
      end
      cycle();
      wrEn = 1'b0;
      #1;
      n_checks++;
      if (rd0 !== '0 || rd1 !== '0 || dr0 !== 1'b0 || dr1 !== 1'b0) begin
         n_fail++; $display("FAIL zero_after: reads %h/%h wrDrop %b/%b expected 0", rd0, rd1, dr0, dr1);
      end
   endtask

   task automatic test_drop_clear();
      assert_reset();
      cycle();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      wrEn  = 1'b1;
      addrW = 5'd3;
      data  = 32'h77;
      cycle();
      #1;
      n_checks++;
      if (dr0 !== 1'b1 || dr1 !== 1'b1 || m_drop !== 1'b1) begin
         n_fail++; $display("FAIL drop_first: got %b/%b expected 1", dr0, dr1);
      end
      cycle();
      wrEn = 1'b0;
      #1;
      n_checks++;
      if (dr0 !== 1'b1 || dr1 !== 1'b1) begin
         n_fail++; $display("FAIL drop_back_to_back: got %b/%b expected 1", dr0, dr1);
      end
      cycle();
      n_checks++;
      if (dr0 !== 1'b0 || dr1 !== 1'b0) begin
         n_fail++; $display("FAIL drop_clears: got %b/%b expected 0", dr0, dr1);
      end
      for (int i = 0; i < 2*DEPTH && m_clear_left > 0; i++) begin
         n_checks++;
         if (bz0 !== 1'b1 || bz1 !== 1'b1) begin
            n_fail++; $display("FAIL drop_busy: got %b/%b expected 1", bz0, bz1);
         end
         cycle();
      end
      addrR = {4{5'd3}};
      #1;
      n_checks++;
      if (bz0 !== 1'b0 || rd0 !== '0 || rd1 !== '0) begin
         n_fail++; $display("FAIL drop_entry3: busy %b reads %h/%h expected 0", bz0, rd0, rd1);
      end
   endtask

   task automatic test_regout_reset();
      wrEn  = 1'b1;
      addrW = 5'd6;
      data  = 32'h55;
      cycle();
      wrEn = 1'b0;
      #1;
      n_checks++;
      if (ro0 !== 32'h55 || ro1 !== 32'h55) begin
         n_fail++; $display("FAIL regout_load: got %h/%h expected 55", ro0, ro1);
      end
      #2;
      assert_reset();
      #1;
      n_checks++;
      if (ro0 !== '0 || ro1 !== '0 || bz0 !== 1'b1 || bz1 !== 1'b1) begin
         n_fail++; $display("FAIL regout_midreset: regOUT %h/%h busy %b/%b expected 0/1", ro0, ro1, bz0, bz1);
      end
      cycle();
      reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_checks++;
         if (bz0 !== 1'b1 || bz1 !== 1'b1) begin
            n_fail++; $display("FAIL midreset_busy[%0d]: got %b/%b expected 1", i, bz0, bz1);
         end
         cycle();
      end
      addrR = {4{5'd6}};
      #1;
      n_checks++;
      if (bz0 !== 1'b0 || rd0 !== '0 || rd1 !== '0 || ro0 !== '0) begin
         n_fail++; $display("FAIL midreset_entry6: busy %b reads %h/%h regOUT %h expected 0", bz0, rd0, rd1, ro0);
      end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a;
      for (int c = 0; c < 400; c++) begin
         wrEn  = 1'($urandom_range(0, 1));
         addrW = ($urandom_range(0, 7) == 0) ? ADDR_W'(OUT_IDX) : ADDR_W'($urandom);
         data  = $urandom;
         for (int k = 0; k < NRD; k++) begin
            a = ($urandom_range(0, 3) == 0) ? addrW : ADDR_W'($urandom);
            addrR[k*ADDR_W +: ADDR_W] = a;
         end
         #1;
         for (int k = 0; k < NRD; k++) begin
            a = addrR[k*ADDR_W +: ADDR_W];
            n_checks++;
            if (rd0[k*DATA_W +: DATA_W] !== exp_read(1'b0, a) || rd1[k*DATA_W +: DATA_W] !== exp_read(1'b1, a)) begin
               n_fail++;
               $display("FAIL rand_read c%0d p%0d a%0d: got %h/%h expected %h/%h", c, k, a,
                        rd0[k*DATA_W +: DATA_W], rd1[k*DATA_W +: DATA_W], exp_read(1'b0, a), exp_read(1'b1, a));
            end
         end
         n_checks++;
         if (ro0 !== m_out || ro1 !== m_out || dr0 !== m_drop || dr1 !== m_drop || bz0 !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_status c%0d: regOUT %h/%h wrDrop %b/%b busy %b expected %h %b 0",
                     c, ro0, ro1, dr0, dr1, bz0, m_out, m_drop);
         end
         cycle();
      end
      wrEn = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      test_reset();
      test_preload_clear();
      test_write_read();
      test_bypass();
      test_zero();
      test_drop_clear();
      test_regout_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
